// File: rtl/counter_nbit_updown_mod.sv
// counter_nbit_updown_mod: parametrised up/down counter with programmable
// modulus, wrap or saturate at the range ends, clock enable, parallel load,
// and registered terminal-count, saturation, compare-match and load-error
// flags. Rc of one stage may drive ce of the next to build longer chains.
`timescale 1ns/1ps
module counter_nbit_updown_mod #(
  parameter int              WIDTH    = 32,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             s,
  input  logic             Load,
  input  logic [WIDTH-1:0] PData,
  input  logic [WIDTH-1:0] Cmp,
  output logic [WIDTH-1:0] cnt,
  output logic             Rc,
  output logic             sat,
  output logic             eq,
  output logic             load_err
);

  // TOP is held one bit wider so MODULUS == 2**WIDTH still fits exactly.
  localparam logic [WIDTH:0]   TOP_X = (WIDTH+1)'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] TOP   = TOP_X[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic             at_top;
  logic             at_zero;
  logic             pdata_oor;
  logic [WIDTH-1:0] cnt_nxt;
  logic             rc_nxt;
  logic             sat_nxt;
  logic             lerr_nxt;

  assign at_top    = ({1'b0, cnt} == TOP_X);
  assign at_zero   = (cnt == '0);
  assign pdata_oor = ({1'b0, PData} > TOP_X);

  // Next-state decode: load beats count, count beats hold.
  always_comb begin
    cnt_nxt  = cnt;
    rc_nxt   = 1'b0;
    sat_nxt  = sat;
    lerr_nxt = 1'b0;
    if (Load) begin
      cnt_nxt  = pdata_oor ? TOP : PData;
      lerr_nxt = pdata_oor;
      sat_nxt  = 1'b0;
    end else if (ce) begin
      if (s) begin
        if (at_top) begin
          rc_nxt  = 1'b1;
          cnt_nxt = SATURATE ? TOP : '0;
          sat_nxt = SATURATE;
        end else begin
          cnt_nxt = cnt + ONE;
          sat_nxt = 1'b0;
        end
      end else begin
        if (at_zero) begin
          rc_nxt  = 1'b1;
          cnt_nxt = SATURATE ? '0 : TOP;
          sat_nxt = SATURATE;
        end else begin
          cnt_nxt = cnt - ONE;
          sat_nxt = 1'b0;
        end
      end
    end
  end

  // Output registers; eq is computed from the next count so it lines up with cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      Rc       <= 1'b0;
      sat      <= 1'b0;
      eq       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      Rc       <= rc_nxt;
      sat      <= sat_nxt;
      eq       <= (cnt_nxt == Cmp);
      load_err <= lerr_nxt;
    end
  end

endmodule

// File: tb/tb_counter_nbit_updown_mod.sv
// Bench for counter_nbit_updown_mod: three instances (mod-10 wrap, mod-10
// saturate, 32-bit full range) share stimulus; an arithmetic reference model
// queues expected outputs and a monitor process compares them each cycle.
`timescale 1ns/1ps
module tb_counter_nbit_updown_mod;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        s = 1'b0;
  logic        Load = 1'b0;
  logic [31:0] PData = '0;
  logic [31:0] Cmp = '0;

  logic [3:0]  cnt0, cnt1;
  logic [31:0] cnt2;
  logic        rc0, rc1, rc2, sat0, sat1, sat2, eq0, eq1, eq2, le0, le1, le2;

  always #5 clk = ~clk;

  counter_nbit_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .ce(ce), .s(s), .Load(Load), .PData(PData[3:0]),
    .Cmp(Cmp[3:0]), .cnt(cnt0), .Rc(rc0), .sat(sat0), .eq(eq0), .load_err(le0));

  counter_nbit_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .ce(ce), .s(s), .Load(Load), .PData(PData[3:0]),
    .Cmp(Cmp[3:0]), .cnt(cnt1), .Rc(rc1), .sat(sat1), .eq(eq1), .load_err(le1));

  counter_nbit_updown_mod u_full (
    .clk(clk), .rst_n(rst_n), .ce(ce), .s(s), .Load(Load), .PData(PData),
    .Cmp(Cmp), .cnt(cnt2), .Rc(rc2), .sat(sat2), .eq(eq2), .load_err(le2));

  typedef struct packed {
    logic [31:0] c0, c1, c2;
    logic [2:0]  rc, st, eq, le;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // reference model state, one slot per instance
  longint unsigned mod_v[3]  = '{64'd10, 64'd10, 64'd4294967296};
  bit              satm[3]   = '{1'b0, 1'b1, 1'b0};
  longint unsigned mask_v[3] = '{64'hF, 64'hF, 64'hFFFF_FFFF};
  longint unsigned m_cnt[3]  = '{0, 0, 0};
  bit              m_rc[3]   = '{0, 0, 0};
  bit              m_sat[3]  = '{0, 0, 0};
  bit              m_eq[3]   = '{0, 0, 0};
  bit              m_le[3]   = '{0, 0, 0};

  task automatic chk(input string nm, input int i, input longint unsigned act,
                     input longint unsigned want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s inst%0d at %0t: got=%0h expected=%0h", nm, i, $time, act, want);
    end
  endtask

  function automatic exp_t pack_model();
    exp_t e;
    e.c0 = 32'(m_cnt[0]);
    e.c1 = 32'(m_cnt[1]);
    e.c2 = 32'(m_cnt[2]);
    for (int i = 0; i < 3; i++) begin
      e.rc[i] = m_rc[i];
      e.st[i] = m_sat[i];
      e.eq[i] = m_eq[i];
      e.le[i] = m_le[i];
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_rc[i] = 0; m_sat[i] = 0; m_eq[i] = 0; m_le[i] = 0;
    end
  endtask

  // One rising edge of the behavioural model, in plain modular arithmetic.
  task automatic model_edge(input bit ce_i, input bit s_i, input bit ld_i,
                            input logic [31:0] pd, input logic [31:0] cmpv);
    longint unsigned top, p, c;
    for (int i = 0; i < 3; i++) begin
      top = mod_v[i] - 1;
      p = longint'(pd) & mask_v[i];
      c = m_cnt[i];
      m_rc[i] = 0;
      m_le[i] = 0;
      if (ld_i) begin
        m_le[i] = (p > top);
        c = (p > top) ? top : p;
        m_sat[i] = 0;
      end else if (ce_i) begin
        if (s_i) begin
          if (c + 1 < mod_v[i]) begin
            c = c + 1; m_sat[i] = 0;
          end else begin
            m_rc[i] = 1;
            if (satm[i]) m_sat[i] = 1;
            else c = (c + 1) % mod_v[i];
          end
        end else begin
          if (c > 0) begin
            c = c - 1; m_sat[i] = 0;
          end else begin
            m_rc[i] = 1;
            if (satm[i]) m_sat[i] = 1;
            else c = (c + mod_v[i] - 1) % mod_v[i];
          end
        end
      end
      m_cnt[i] = c;
      m_eq[i] = (c == (longint'(cmpv) & mask_v[i]));
    end
  endtask

  // Drive one cycle of inputs (releasing any pending reset) and queue the result.
  task automatic step(input bit ce_i, input bit s_i, input bit ld_i,
                      input logic [31:0] pd, input logic [31:0] cmpv);
    @(posedge clk); #2;
    rst_n = 1'b1;
    ce = ce_i; s = s_i; Load = ld_i; PData = pd; Cmp = cmpv;
    model_edge(ce_i, s_i, ld_i, pd, cmpv);
    q.push_back(pack_model());
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cnt"}, 0, cnt0, 0);
    chk({tag, "_cnt"}, 1, cnt1, 0);
    chk({tag, "_cnt"}, 2, cnt2, 0);
    chk({tag, "_rc"}, 0, {63'd0, rc0} | {63'd0, rc1} | {63'd0, rc2}, 0);
    chk({tag, "_eq"}, 0, {63'd0, eq0} | {63'd0, eq1} | {63'd0, eq2}, 0);
    chk({tag, "_sat"}, 1, {63'd0, sat0} | {63'd0, sat1} | {63'd0, sat2}, 0);
    chk({tag, "_lerr"}, 0, {63'd0, le0} | {63'd0, le1} | {63'd0, le2}, 0);
  endtask

  // Assert reset between edges; stays low through the next edge.
  task automatic reset_mid();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    model_reset();
    q.push_back(pack_model());
  endtask

  // Monitor: compare queued expectations just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cnt", 0, cnt0, e.c0);
        chk("cnt", 1, cnt1, e.c1);
        chk("cnt", 2, cnt2, e.c2);
        chk("rc", 0, rc0, e.rc[0]);
        chk("rc", 1, rc1, e.rc[1]);
        chk("rc", 2, rc2, e.rc[2]);
        chk("sat", 0, sat0, e.st[0]);
        chk("sat", 1, sat1, e.st[1]);
        chk("sat", 2, sat2, e.st[2]);
        chk("eq", 0, eq0, e.eq[0]);
        chk("eq", 1, eq1, e.eq[1]);
        chk("eq", 2, eq2, e.eq[2]);
        chk("lerr", 0, le0, e.le[0]);
        chk("lerr", 1, le1, e.le[1]);
        chk("lerr", 2, le2, e.le[2]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pd, cv;
    int r;
    #3;
    check_all_zero("reset");

    // count up across two wraps
    for (int k = 0; k < 25; k++) step(1'b1, 1'b1, 1'b0, 32'd0, 32'd3);
    // count down from a fresh zero: first edge wraps to TOP
    reset_mid();
    for (int k = 0; k < 22; k++) step(1'b1, 1'b0, 1'b0, 32'd0, 32'd9);
    // load 8, push up into the top end, then step back down
    step(1'b0, 1'b0, 1'b1, 32'd8, 32'd9);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 32'd0, 32'd9);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd8);
    // out-of-range load with ce/s asserted on the same edge
    step(1'b1, 1'b1, 1'b1, 32'd15, 32'd9);
    step(1'b1, 1'b1, 1'b0, 32'd0, 32'd9);
    // full-width wrap with compare at zero
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'd0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
    // clock enable low: hold, no Rc
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    // saturate at zero then leave
    step(1'b0, 1'b0, 1'b1, 32'd1, 32'd0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 32'd1);
    // mid-count reset
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 32'd0, 32'd5);
    reset_mid();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0: pd = $urandom_range(0, 15);
        1: pd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        2: pd = $urandom;
        default: pd = $urandom_range(0, 9);
      endcase
      r = int'($urandom_range(0, 7));
      cv = (r == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 15));
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 15) == 0), pd, cv);
      if ($urandom_range(0, 99) == 0) reset_mid();
    end

    @(posedge clk);
    @(posedge clk); #3;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d pending expected=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
